// File: rtl/crono_pkg.sv
// -----------------------------------------------------------------------------
// crono_pkg: shared types and helpers for the crono_regresivo countdown timer.
//   - crono_state_e : controller states (IDLE, RUN, PAUSE, DONE)
//   - BCD_59/BCD_00 : BCD field constants
//   - bcd_clamp()   : replaces an invalid or out-of-range BCD field by its max
// -----------------------------------------------------------------------------
package crono_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } crono_state_e;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_00 = 8'h00;

    // Any non-decimal digit or a value above max_v collapses to max_v.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > max_v)) begin
            r = max_v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/crono_bcd_dec.sv
// -----------------------------------------------------------------------------
// crono_bcd_dec: two-digit BCD down-counter register.
//   clk_i, rst_ni      : clock, asynchronous active-low reset (clears to 00)
//   load_i, load_val_i : synchronous load (priority over decrement)
//   dec_i              : decrement by one this cycle
//   wrap_i             : value taken when decrementing from 00
//   q_o                : registered count
//   borrow_o           : high when a decrement wraps from 00 (feeds next field)
// -----------------------------------------------------------------------------
module crono_bcd_dec
    import crono_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    input  logic [7:0] wrap_i,
    output logic [7:0] q_o,
    output logic       borrow_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next count: load, BCD decrement with tens borrow, or hold.
    always_comb begin
        q_d      = q_q;
        borrow_o = 1'b0;
        if (load_i) begin
            q_d = load_val_i;
        end else if (dec_i) begin
            if (q_q == BCD_00) begin
                q_d      = wrap_i;
                borrow_o = 1'b1;
            end else if (q_q[3:0] == 4'h0) begin
                q_d = {q_q[7:4] - 4'h1, 4'h9};
            end else begin
                q_d = q_q - 8'h01;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= BCD_00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/crono_regresivo.sv
// -----------------------------------------------------------------------------
// crono_regresivo: BCD HH:MM:SS countdown chronometer.
//   CLK_Ring, reset         : clock, asynchronous active-low reset
//   load                    : capture clamped hh_in/mm_in/ss_in as preset+count
//   start / stop            : begin-resume / pause strobes (load > stop > start)
//   ack_alarma              : clears fin_crono
//   hh, mm, ss              : current BCD count
//   running                 : high while counting
//   fin_crono               : expiry flag for the alarm stage
// Optional build macro CRONO_AUTORELOAD_EN: on expiry the count reloads from
// the preset and keeps running; fin_crono becomes a sticky flag.
// -----------------------------------------------------------------------------
module crono_regresivo
    import crono_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,
    parameter logic [7:0]  HH_MAX   = 8'h23
) (
    input  logic       CLK_Ring,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       ack_alarma,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       fin_crono
);

    localparam int unsigned   PW        = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 32'd1);

    crono_state_e  state_q;
    logic [PW-1:0] presc_q;
    logic [7:0]    pre_hh_q, pre_mm_q, pre_ss_q;
    logic          running_q, fin_q;

    logic [7:0] hh_s, mm_s, ss_s;
    logic [7:0] cl_hh_s, cl_mm_s, cl_ss_s;
    logic [7:0] ld_hh_s, ld_mm_s, ld_ss_s;
    logic       tick_s, expire_s, cnt_zero_s, reload_s, cnt_ld_s, dec_s, fin_keep_s;
    logic       ss_borrow_s, mm_borrow_s, hh_borrow_unused_s;

    // Tick, expiry detection and counter control.
    always_comb begin
        cl_hh_s    = bcd_clamp(hh_in, HH_MAX);
        cl_mm_s    = bcd_clamp(mm_in, BCD_59);
        cl_ss_s    = bcd_clamp(ss_in, BCD_59);
        tick_s     = (state_q == ST_RUN) && (presc_q == TICK_LAST);
        cnt_zero_s = (hh_s == BCD_00) && (mm_s == BCD_00) && (ss_s == BCD_00);
        // The tick taken at 00:00:01 is the one that lands on zero.
        expire_s   = tick_s && !load && (hh_s == BCD_00) && (mm_s == BCD_00)
                     && (ss_s == 8'h01);
`ifdef CRONO_AUTORELOAD_EN
        reload_s   = expire_s;
        fin_keep_s = fin_q && !ack_alarma;
`else
        reload_s   = 1'b0;
        fin_keep_s = 1'b0;
`endif
        cnt_ld_s   = load || reload_s;
        dec_s      = tick_s && !cnt_ld_s;
        if (load) begin
            ld_hh_s = cl_hh_s;
            ld_mm_s = cl_mm_s;
            ld_ss_s = cl_ss_s;
        end else begin
            ld_hh_s = pre_hh_q;
            ld_mm_s = pre_mm_q;
            ld_ss_s = pre_ss_q;
        end
    end

    crono_bcd_dec u_ss (
        .clk_i(CLK_Ring), .rst_ni(reset), .load_i(cnt_ld_s), .load_val_i(ld_ss_s),
        .dec_i(dec_s), .wrap_i(BCD_59), .q_o(ss_s), .borrow_o(ss_borrow_s)
    );

    crono_bcd_dec u_mm (
        .clk_i(CLK_Ring), .rst_ni(reset), .load_i(cnt_ld_s), .load_val_i(ld_mm_s),
        .dec_i(ss_borrow_s), .wrap_i(BCD_59), .q_o(mm_s), .borrow_o(mm_borrow_s)
    );

    // Hours never wrap in practice: expiry stops or reloads before 00:00:00 - 1.
    crono_bcd_dec u_hh (
        .clk_i(CLK_Ring), .rst_ni(reset), .load_i(cnt_ld_s), .load_val_i(ld_hh_s),
        .dec_i(mm_borrow_s), .wrap_i(BCD_00), .q_o(hh_s), .borrow_o(hh_borrow_unused_s)
    );

    // Controller FSM, prescaler, preset capture and registered status flags.
    always_ff @(posedge CLK_Ring or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= {PW{1'b0}};
            pre_hh_q  <= BCD_00;
            pre_mm_q  <= BCD_00;
            pre_ss_q  <= BCD_00;
            running_q <= 1'b0;
            fin_q     <= 1'b0;
        end else if (load) begin
            state_q   <= ST_IDLE;
            presc_q   <= {PW{1'b0}};
            pre_hh_q  <= cl_hh_s;
            pre_mm_q  <= cl_mm_s;
            pre_ss_q  <= cl_ss_s;
            running_q <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        presc_q <= {PW{1'b0}};
                        if (cnt_zero_s) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            fin_q     <= 1'b1;
                        end else begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            fin_q     <= fin_keep_s;
                        end
                    end else begin
                        fin_q <= fin_keep_s;
                    end
                end
                ST_RUN: begin
                    presc_q <= tick_s ? {PW{1'b0}} : (presc_q + PW'(1'b1));
                    if (expire_s) begin
`ifdef CRONO_AUTORELOAD_EN
                        fin_q <= 1'b1;
                        if (stop) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
`else
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        fin_q     <= 1'b1;
`endif
                    end else if (stop) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                        fin_q     <= fin_keep_s;
                    end else begin
                        fin_q <= fin_keep_s;
                    end
                end
                ST_PAUSE: begin
                    // Prescaler holds so a resume continues the partial second.
                    if (start) begin
                        if (cnt_zero_s) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            fin_q     <= 1'b1;
                        end else begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            fin_q     <= fin_keep_s;
                        end
                    end else begin
                        fin_q <= fin_keep_s;
                    end
                end
                ST_DONE: begin
                    if (ack_alarma) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        fin_q     <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                        fin_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    presc_q   <= {PW{1'b0}};
                    running_q <= 1'b0;
                    fin_q     <= 1'b0;
                end
            endcase
        end
    end

    assign hh        = hh_s;
    assign mm        = mm_s;
    assign ss        = ss_s;
    assign running   = running_q;
    assign fin_crono = fin_q;

endmodule

// File: tb/tb_crono_regresivo.sv
// -----------------------------------------------------------------------------
// tb_crono_regresivo: scoreboard bench for crono_regresivo with TICK_DIV=4.
// Stimulus pushes {cycle, expected outputs} into a queue before driving the
// strobe; a monitor samples 1 time unit after each rising edge and checks
// every entry whose cycle has been reached.
// -----------------------------------------------------------------------------
module tb_crono_regresivo;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       ack   = 1'b0;
    logic [7:0] hh_in = 8'h00;
    logic [7:0] mm_in = 8'h00;
    logic [7:0] ss_in = 8'h00;
    logic [7:0] hh, mm, ss;
    logic       running, fin_crono;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] hh, mm, ss;
        logic       run, fin;
        string      tag;
    } exp_t;

    exp_t sb[$];

    crono_regresivo #(.TICK_DIV(4), .HH_MAX(8'h23)) dut (
        .CLK_Ring(clk), .reset(rst_n), .load(load), .start(start), .stop(stop),
        .ack_alarma(ack), .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
        .hh(hh), .mm(mm), .ss(ss), .running(running), .fin_crono(fin_crono)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input exp_t e);
        checks++;
        if ({hh, mm, ss, running, fin_crono} !== {e.hh, e.mm, e.ss, e.run, e.fin}) begin
            errors++;
            $display("FAIL %s cyc %0d: got %h:%h:%h run=%b fin=%b, want %h:%h:%h run=%b fin=%b",
                     e.tag, cyc, hh, mm, ss, running, fin_crono, e.hh, e.mm, e.ss, e.run, e.fin);
        end
    endtask

    // Monitor: check every expectation due at or before this cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            compare(e);
        end
    end

    task automatic expect_at(input int c, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s, input logic r, input logic f, input string t);
        exp_t e;
        e.cyc = c; e.hh = h; e.mm = m; e.ss = s; e.run = r; e.fin = f; e.tag = t;
        sb.push_back(e);
    endtask

    // All drive tasks are entered at a falling edge; the strobe is captured at cycle cyc+1.
    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic with_ack);
        hh_in = h; mm_in = m; ss_in = s; load = 1'b1; ack = with_ack;
        @(negedge clk);
        load = 1'b0; ack = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            0:       start = 1'b1;
            1:       stop  = 1'b1;
            default: ack   = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; stop = 1'b0; ack = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int e, s, p, r;
        exp_t d;

        // Reset state
        @(negedge clk); @(negedge clk);
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CRONO_AUTORELOAD_EN
        // Auto-reload: expiry reloads 02 and sets sticky fin while running
        e = cyc + 1; expect_at(e, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, "ar_load");
        do_load(8'h00, 8'h00, 8'h02, 1'b0);
        s = cyc + 1;
        expect_at(s,      8'h00, 8'h00, 8'h02, 1'b1, 1'b0, "ar_start");
        expect_at(s + 4,  8'h00, 8'h00, 8'h01, 1'b1, 1'b0, "ar_tick1");
        expect_at(s + 8,  8'h00, 8'h00, 8'h02, 1'b1, 1'b1, "ar_reload");
        expect_at(s + 12, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1, "ar_sticky");
        pulse(0);
        wait_until(s + 12);
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, "ar_ack");
        pulse(2);
`else
        // Basic countdown 00:00:03 to expiry, fin held until ack
        e = cyc + 1; expect_at(e, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, "load3");
        do_load(8'h00, 8'h00, 8'h03, 1'b0);
        s = cyc + 1;
        expect_at(s,      8'h00, 8'h00, 8'h03, 1'b1, 1'b0, "start3");
        expect_at(s + 4,  8'h00, 8'h00, 8'h02, 1'b1, 1'b0, "tick_02");
        expect_at(s + 8,  8'h00, 8'h00, 8'h01, 1'b1, 1'b0, "tick_01");
        expect_at(s + 12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, "expire");
        for (int k = 1; k <= 20; k++)
            expect_at(s + 12 + k, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, "fin_hold");
        pulse(0);
        wait_until(s + 32);
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "ack_clear");
        pulse(2);
`endif

        // Borrow through minutes and hours
        expect_at(cyc + 1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, "load_1h");
        do_load(8'h01, 8'h00, 8'h00, 1'b0);
        s = cyc + 1;
        expect_at(s,     8'h01, 8'h00, 8'h00, 1'b1, 1'b0, "start_1h");
        expect_at(s + 4, 8'h00, 8'h59, 8'h59, 1'b1, 1'b0, "borrow_hh");
        pulse(0);
        wait_until(s + 4);
        expect_at(cyc + 1, 8'h00, 8'h59, 8'h59, 1'b0, 1'b0, "stop_1h");
        pulse(1);

        // Tens-digit borrow inside minutes
        expect_at(cyc + 1, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, "load_10m");
        do_load(8'h00, 8'h10, 8'h00, 1'b0);
        s = cyc + 1;
        expect_at(s + 4, 8'h00, 8'h09, 8'h59, 1'b1, 1'b0, "borrow_mm");
        pulse(0);
        wait_until(s + 4);

        // Clamping of invalid or out-of-range fields, and valid boundaries
        expect_at(cyc + 1, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0, "clamp_all");
        do_load(8'h30, 8'h7A, 8'h61, 1'b0);
        expect_at(cyc + 1, 8'h09, 8'h59, 8'h59, 1'b0, 1'b0, "clamp_mm_ss");
        do_load(8'h09, 8'h5F, 8'h60, 1'b0);
        expect_at(cyc + 1, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0, "clamp_hh24");
        do_load(8'h24, 8'h59, 8'h59, 1'b0);
        expect_at(cyc + 1, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, "no_clamp");
        do_load(8'h12, 8'h34, 8'h56, 1'b0);
        s = cyc + 1;
        expect_at(s + 4, 8'h12, 8'h34, 8'h55, 1'b1, 1'b0, "dec_12");
        pulse(0);
        wait_until(s + 4);

        // Pause keeps the count and the prescaler phase
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, "load5");
        do_load(8'h00, 8'h00, 8'h05, 1'b0);
        s = cyc + 1;
        expect_at(s, 8'h00, 8'h00, 8'h05, 1'b1, 1'b0, "start5");
        pulse(0);
        wait_until(s + 1);
        p = cyc + 1;
        expect_at(p,      8'h00, 8'h00, 8'h05, 1'b0, 1'b0, "pause");
        expect_at(p + 10, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, "pause_hold");
        pulse(1);
        wait_until(p + 10);
        r = cyc + 1;
        expect_at(r,     8'h00, 8'h00, 8'h05, 1'b1, 1'b0, "resume");
        expect_at(r + 1, 8'h00, 8'h00, 8'h05, 1'b1, 1'b0, "resume_1");
        expect_at(r + 2, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, "resume_tick");
        pulse(0);
        wait_until(r + 2);
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, "ack_ignored");
        pulse(2);

        // Asynchronous reset mid-run
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0, "load9");
        do_load(8'h00, 8'h00, 8'h09, 1'b0);
        s = cyc + 1;
        expect_at(s + 4, 8'h00, 8'h00, 8'h08, 1'b1, 1'b0, "tick_08");
        pulse(0);
        wait_until(s + 6);
        #2;
        rst_n = 1'b0;
        #1;
        d.cyc = cyc; d.hh = 8'h00; d.mm = 8'h00; d.ss = 8'h00; d.run = 1'b0; d.fin = 1'b0;
        d.tag = "async_reset";
        compare(d);
        @(negedge clk);
        rst_n = 1'b1;

        // Start with a zero count goes straight to DONE
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, "zero_start");
        pulse(0);

        // Load together with ack in DONE: back to IDLE with the new preset
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0, "load_ack");
        do_load(8'h00, 8'h00, 8'h07, 1'b1);
        expect_at(cyc + 1, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0, "idle_start");
        pulse(0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        while (sb.size() > 0) begin
            d = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s timeout: expectation for cycle %0d never checked (now %0d)",
                     d.tag, d.cyc, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crono_regresivo.md
Name: crono_regresivo

Overview:
- Countdown chronometer that produces `fin_crono` for the alarm/blink stage.
- Counts a BCD HH:MM:SS preset down to 00:00:00 at one decrement per prescaled tick, then raises `fin_crono`.
- Holds `fin_crono` high until the alarm side acknowledges it or a new preset is loaded.
- Sits between the user-input/config logic and the alarm block; also drives the display with the current count.

Parameters:
- TICK_DIV, 100000000, CLK_Ring cycles per one-second tick; minimum 2.
- HH_MAX, 8'h23, maximum BCD hours value; larger loads are clamped to this.

Ports:
- CLK_Ring  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; capture hh_in/mm_in/ss_in as preset and count.
- start  in  1  one-cycle strobe; begin or resume counting.
- stop  in  1  one-cycle strobe; pause counting.
- ack_alarma  in  1  alarm-side acknowledge; clears fin_crono.
- hh_in  in  8  BCD hours preset.
- mm_in  in  8  BCD minutes preset.
- ss_in  in  8  BCD seconds preset.
- hh  out  8  current BCD hours.
- mm  out  8  current BCD minutes.
- ss  out  8  current BCD seconds.
- running  out  1  high in RUN.
- fin_crono  out  1  high in DONE (level signal).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; hh/mm/ss=0; preset=0; prescaler=0; running=0; fin_crono=0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: tick decrements the count; stop -> PAUSE; reaching 00:00:00 -> DONE.
  - PAUSE: start -> RUN; prescaler holds its value.
  - DONE: ack_alarma or load -> IDLE.
- Load:
  - Accepted in any state; count and preset both get the clamped inputs the next cycle; state goes to IDLE; prescaler clears.
  - Clamping is per field: any invalid BCD digit, ss/mm > 8'h59, or hh > HH_MAX is replaced by 59/59/HH_MAX.
- Start:
  - From IDLE, prescaler clears, so the first decrement comes exactly TICK_DIV cycles after the start edge.
  - From PAUSE, counting resumes from the held prescaler value.
  - If the count is 00:00:00, start goes directly to DONE the next cycle, with fin_crono=1.
- Tick: one-cycle internal pulse when prescaler == TICK_DIV-1; prescaler then wraps to 0. Prescaler runs only in RUN.
- Decrement (BCD with borrow):
  - ss 00 -> 59 and borrows from mm.
  - mm 00 -> 59 and borrows from hh.
  - The tick that produces 00:00:00 also moves the state to DONE; fin_crono rises in the same cycle the outputs show zero.
- Priority of simultaneous strobes: load > stop > start. ack_alarma outside DONE is ignored.
- Reset asserted mid-count: immediate return to the reset values; the preset is lost.

Optional Feature:
- Macro: CRONO_AUTORELOAD_EN.
- Defined:
  - On reaching zero, the count reloads from the preset on the same tick and the state stays RUN.
  - fin_crono is a sticky flag set at each expiry and cleared by ack_alarma or load; running stays 1.
  - A zero preset behaves as without the macro, to avoid continuous expiry.
- Undefined: behaviour exactly as above (DONE state, counting stops).

Decomposition:
- Package crono_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - BCD constants: BCD_59=8'h59, BCD_00=8'h00;
  - a clamp function used for the preset fields.
- One natural sub-module, crono_bcd_dec: 2-digit BCD down-counter with enable, wrap value, and borrow-out. Instantiated three times (ss, mm, hh), with hh using wrap 00 and no borrow.

Test Plan:
- Benches use TICK_DIV=4.
- Load 00:00:03, start -> ss=02 at 4 cycles after the start edge, 01 at 8, 00 at 12; at 12 fin_crono=1 and running=0. Hold ack_alarma low for 20 cycles -> fin_crono stays 1. Pulse ack -> fin_crono=0, state IDLE.
- Load 01:00:00, start -> after the first tick the count is 00:59:59.
- Load hh_in=8'h30, mm_in=8'h7A, ss_in=8'h61 -> outputs read 23:59:59.
- Load 00:00:05, start, stop 2 cycles later, wait 10 cycles (count stays 05), start -> 04 appears 2 cycles after the resume.
- Start with count 00:00:00 -> fin_crono=1 the next cycle. Assert load and ack_alarma in the same cycle -> IDLE, new preset shown.
- Drop reset mid-RUN, asynchronously between clock edges -> all outputs 0 immediately. With CRONO_AUTORELOAD_EN: load 00:00:02, start -> fin_crono sets at cycle 8, count reads 02, running stays 1.
